// File: rtl/sobel_cap_pkg.sv
// Shared types and frame geometry for the Sobel frame capture block.
// Defaults describe a 640x480 frame packed into 32-bit BRAM words.
package sobel_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DONE
  } cap_state_e;

  localparam int H_ACT_DEF  = 640;
  localparam int V_ACT_DEF  = 480;
  localparam int PACK_W_DEF = 32;
  localparam int ADDR_W_DEF = 14;

  localparam int FRAME_PIX       = H_ACT_DEF * V_ACT_DEF;
  localparam int WORDS_PER_FRAME = FRAME_PIX / PACK_W_DEF;

  function automatic int frame_pix(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/sobel_frame_capture_if.sv
// Edge-stream input and BRAM write port of the frame capture block.
// master = capture core, slave = surrounding pixel source / memory.
interface sobel_frame_capture_if #(
  parameter int PACK_W = 32,
  parameter int ADDR_W = 14
);

  logic              frame_start;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [PACK_W-1:0] bram_wdata;

  modport master (
    input  frame_start,
    input  pix_valid,
    input  pix_data,
    output bram_we,
    output bram_addr,
    output bram_wdata
  );

  modport slave (
    output frame_start,
    output pix_valid,
    output pix_data,
    input  bram_we,
    input  bram_addr,
    input  bram_wdata
  );

endinterface

// File: rtl/sobel_bit_packer.sv
// Packs edge bits LSB-first into PACK_W-bit words; emits each word
// one cycle after its last bit, or a zero-filled partial word on flush.
module sobel_bit_packer #(
  parameter int PACK_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic              bit_i,
  input  logic              flush_i,
  output logic              word_valid_o,
  output logic [PACK_W-1:0] word_o
);

  localparam int CW = $clog2(PACK_W);

  logic [PACK_W-1:0] sr_q;
  logic [PACK_W-1:0] sr_d;
  logic [CW-1:0]     cnt_q;
  logic              vld_q;
  logic [PACK_W-1:0] word_q;

  // Newest bit enters at the top so pixel 0 ends up in bit 0.
  assign sr_d = {bit_i, sr_q[PACK_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      vld_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (take_i) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          vld_q  <= 1'b1;
          word_q <= sr_d;
        end
      end else if (flush_i && cnt_q != '0) begin
        // Shifting right drops stale low bits and zero-fills the top.
        vld_q  <= 1'b1;
        word_q <= sr_q >> (PACK_W - int'(cnt_q));
        cnt_q  <= '0;
      end
    end
  end

  assign word_valid_o = vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/sobel_frame_capture.sv
// Captures one armed frame of Sobel edge bits into BRAM words.
// SOBEL_EDGE_COUNT_EN adds edge_count (edge pixels in last capture).
module sobel_frame_capture
  import sobel_cap_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int PACK_W = PACK_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        abort,
  sobel_frame_capture_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        err_short
`ifdef SOBEL_EDGE_COUNT_EN
  ,
  output logic [18:0] edge_count
`endif
);

  localparam int FRAME = frame_pix(H_ACT, V_ACT);
  localparam int PW    = $clog2(FRAME + 1);

  cap_state_e        st_q;
  logic [PW-1:0]     pix_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              arm_ok;
  logic              sat;
  logic              take;
  logic              last;
  logic              short_f;
  logic              word_vld;
  logic [PACK_W-1:0] word;
  logic              unused_pix;

  assign unused_pix = ^bus.pix_data[7:1];

  always_comb begin
    arm_ok  = (st_q == IDLE) && arm && !abort;
    sat     = (pix_q == PW'(FRAME));
    take    = bus.pix_valid && !abort && !sat &&
              (((st_q == CAPTURE) && !bus.frame_start) ||
               ((st_q == WAIT_SOF) && bus.frame_start));
    last    = take && (pix_q == PW'(FRAME - 1));
    short_f = (st_q == CAPTURE) && bus.frame_start && !abort;
  end

  sobel_bit_packer #(
    .PACK_W(PACK_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (arm_ok || abort),
    .take_i      (take),
    .bit_i       (bus.pix_data[0]),
    .flush_i     (short_f),
    .word_valid_o(word_vld),
    .word_o      (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      pix_q  <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (arm_ok)    pix_q <= '0;
      else if (take) pix_q <= pix_q + 1'b1;
      if (arm_ok)        addr_q <= '0;
      else if (word_vld) addr_q <= addr_q + 1'b1;
      if (abort) begin
        st_q   <= IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (st_q)
          IDLE: if (arm) begin
            st_q   <= WAIT_SOF;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
          end
          WAIT_SOF: if (bus.frame_start) begin
            st_q   <= last ? DONE : CAPTURE;
            busy_q <= !last;
          end
          CAPTURE: if (short_f) begin
            st_q   <= DONE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else if (last) begin
            st_q   <= DONE;
            busy_q <= 1'b0;
          end
          DONE: begin
            st_q   <= IDLE;
            done_q <= 1'b1;
          end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.bram_we    = word_vld;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = word;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_short      = err_q;

`ifdef SOBEL_EDGE_COUNT_EN
  logic [18:0] ecnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ecnt_q <= '0;
    else if (arm_ok)                  ecnt_q <= '0;
    else if (take && bus.pix_data[0]) ecnt_q <= ecnt_q + 1'b1;
  end

  assign edge_count = ecnt_q;
`endif

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Self-checking bench for sobel_frame_capture on a reduced 16x8 frame
// packed into 8-bit words (16 words per frame).
module tb_sobel_frame_capture;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int PW    = 8;
  localparam int AW    = 5;
  localparam int FRAME = H * V;
  localparam int WORDS = FRAME / PW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic arm   = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;
  logic err_short;
`ifdef SOBEL_EDGE_COUNT_EN
  logic [18:0] edge_count;
`endif

  sobel_frame_capture_if #(.PACK_W(PW), .ADDR_W(AW)) bus ();

  sobel_frame_capture #(
    .H_ACT (H),
    .V_ACT (V),
    .PACK_W(PW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err_short (err_short)
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    .edge_count(edge_count)
`endif
  );

  always #5 clk = ~clk;

  logic [AW-1:0] wa[$];
  logic [PW-1:0] wd[$];
  int done_total = 0;

  always @(negedge clk) begin
    if (bus.bram_we === 1'b1) begin
      wa.push_back(bus.bram_addr);
      wd.push_back(bus.bram_wdata);
    end
    if (done === 1'b1) done_total++;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic ab, input logic fs,
                     input logic v, input logic e);
    @(negedge clk);
    arm             = a;
    abort           = ab;
    bus.frame_start = fs;
    bus.pix_valid   = v;
    bus.pix_data    = {7'd0, e};
  endtask

  function automatic logic edge_of(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return n[0];
      2:       return 1'b0;
      3:       return n[1];
      default: return n[0] ^ ((n / H) % 2 == 1);
    endcase
  endfunction

  function automatic logic [PW-1:0] exp_word(input int mode, input int w);
    logic [PW-1:0] r;
    r = '0;
    for (int b = 0; b < PW; b++) r[b] = edge_of(mode, w * PW + b);
    return r;
  endfunction

  task automatic feed_frame(input int mode, input bit gaps,
                            input int rearm_at);
    for (int n = 0; n < FRAME; n++) begin
      if (gaps && n != 0)
        repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 1'b1);
      cyc(n == rearm_at, 0, n == 0, 1, edge_of(mode, n));
    end
    cyc(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int            mode;
    bit            gaps;
    bit            rearm;
    logic [PW-1:0] w0;
    int            edges;
  } vec_t;

  vec_t vt[6];
  int base;
  int d0;
  int nw;

  initial begin
    vt[0] = '{0, 1'b0, 1'b0, 8'hFF, 128};
    vt[1] = '{1, 1'b0, 1'b1, 8'hAA, 64};
    vt[2] = '{1, 1'b1, 1'b0, 8'hAA, 64};
    vt[3] = '{2, 1'b1, 1'b1, 8'h00, 0};
    vt[4] = '{3, 1'b1, 1'b0, 8'hCC, 64};
    vt[5] = '{4, 1'b0, 1'b0, 8'hAA, 64};

    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'd0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("rst_we", bus.bram_we, 0);
    chk("rst_addr", bus.bram_addr, 0);
    chk("rst_wdata", bus.bram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_short, 0);

    for (int i = 0; i < 6; i++) begin
      base = wa.size();
      d0   = done_total;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("busy_armed", busy, 1);
      repeat (5) cyc(0, 0, 0, 1, 1);
      feed_frame(vt[i].mode, vt[i].gaps, vt[i].rearm ? 60 : -1);
      repeat (6) cyc(0, 0, 0, 1, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      nw = wa.size() - base;
      chk("frame_writes", nw, WORDS);
      for (int w = 0; w < WORDS; w++) begin
        if (w < nw) begin
          chk("frame_addr", wa[base + w], w);
          chk("frame_data", wd[base + w], exp_word(vt[i].mode, w));
        end
      end
      if (nw > 0) chk("frame_word0", wd[base], vt[i].w0);
      chk("frame_done", done_total - d0, 1);
      chk("frame_err", err_short, 0);
      chk("frame_busy", busy, 0);
`ifdef SOBEL_EDGE_COUNT_EN
      chk("edge_count", edge_count, vt[i].edges);
`endif
    end

    // short frame: 20 pixels then a new frame_start
    base = wa.size();
    d0   = done_total;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) cyc(0, 0, n == 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    for (int n = 0; n < 30; n++) cyc(0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    nw = wa.size() - base;
    chk("short_writes", nw, 3);
    if (nw == 3) begin
      chk("short_a2", wa[base + 2], 2);
      chk("short_d1", wd[base + 1], 8'hFF);
      chk("short_d2", wd[base + 2], 8'h0F);
    end
    chk("short_done", done_total - d0, 1);
    chk("short_err", err_short, 1);
    chk("short_busy", busy, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rearm_err_clr", err_short, 0);
    chk("rearm_busy", busy, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("abort_idle_busy", busy, 0);

    // abort while word 5 write is in flight
    base = wa.size();
    d0   = done_total;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 48; n++) cyc(0, 0, n == 0, 1, 1);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("abort_busy", busy, 0);
    for (int n = 0; n < 40; n++) cyc(0, 0, n == 20, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    nw = wa.size() - base;
    chk("abort_writes", nw, 6);
    if (nw == 6) chk("abort_last_addr", wa[base + 5], 5);
    chk("abort_no_done", done_total - d0, 0);

    // arm and abort together: abort wins
    base = wa.size();
    d0   = done_total;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("armabort_busy", busy, 0);
    for (int n = 0; n < 20; n++) cyc(0, 0, n == 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("armabort_writes", wa.size() - base, 0);
    chk("armabort_done", done_total - d0, 0);

    // asynchronous reset in the middle of a capture
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 25; n++) cyc(0, 0, n == 0, 1, 1);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", bus.bram_we, 0);
    chk("arst_addr", bus.bram_addr, 0);
    chk("arst_wdata", bus.bram_wdata, 0);
    chk("arst_busy", busy, 0);
`ifdef SOBEL_EDGE_COUNT_EN
    chk("arst_edges", edge_count, 0);
`endif
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
